// File: rtl/posit_op_arbiter.sv
// posit_op_arbiter
// Round-robin arbiter/sequencer sharing one posit arithmetic unit among
// NUM_REQ requesters. One operation is in flight at a time: it is accepted,
// issued to the unit with a single start pulse, and awaited. Its result is
// then returned to the owning requester as a one-cycle response. A watchdog
// aborts operations the unit never finishes and returns NaR instead.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   per-requester request handshake (ready is one-hot or 0)
//   req_opcode/a/b    packed per-requester opcode (2b) and operands
//   rsp_valid         one-hot, one-cycle response strobe
//   rsp_result/zero   result and zero flag, held until the next response
//   rsp_timeout       set when the response came from the watchdog
//   unit_start        one-cycle start pulse to the shared unit
//   unit_opcode/a/b   operands to the unit, held for the whole operation
//   unit_done/zero/result  completion inputs from the unit
//   busy              high whenever the FSM is not IDLE
//   dbg_state         current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshake: a request transfers on the rising clk edge where
// req_valid[i] && req_ready[i]. req_ready is only raised in IDLE, for the
// single requester chosen by the round-robin search, and never during reset.
// req_valid may be withdrawn at any time before that edge. rsp_valid has no
// backpressure and must be sampled when it is high.

module posit_op_arbiter #(
  parameter int posit_width = 8,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_opcode,
  input  logic [posit_width*NUM_REQ-1:0] req_a,
  input  logic [posit_width*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [posit_width-1:0]         rsp_result,
  output logic                           rsp_zero,
  output logic                           rsp_timeout,
  output logic                           unit_start,
  output logic [1:0]                     unit_opcode,
  output logic [posit_width-1:0]         unit_a,
  output logic [posit_width-1:0]         unit_b,
  input  logic                           unit_done,
  input  logic                           unit_zero,
  input  logic [posit_width-1:0]         unit_result,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [CW-1:0]          CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [posit_width-1:0] NAR      = {1'b1, {(posit_width-1){1'b0}}};

  logic [1:0]             r_state;
  logic [GW-1:0]          r_rr_ptr;
  logic [GW-1:0]          r_grant;
  logic [CW-1:0]          r_cnt;
  logic                   r_done_q;
  logic [1:0]             r_opcode;
  logic [posit_width-1:0] r_a;
  logic [posit_width-1:0] r_b;
  logic [posit_width-1:0] r_rsp_result;
  logic                   r_rsp_zero;
  logic                   r_rsp_timeout;

  logic                   w_gnt_found;
  logic [GW-1:0]          w_gnt_idx;
  logic [1:0]             w_sel_opcode;
  logic [posit_width-1:0] w_sel_a;
  logic [posit_width-1:0] w_sel_b;
  logic                   w_handshake;
  logic                   w_done_rise;
  logic [CW-1:0]          w_cnt_next;

  // First valid requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    int idx;
    idx          = 0;
    w_gnt_found  = 1'b0;
    w_gnt_idx    = '0;
    w_sel_opcode = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_gnt_found && req_valid[idx]) begin
        w_gnt_found  = 1'b1;
        w_gnt_idx    = GW'(idx);
        w_sel_opcode = req_opcode[2*idx +: 2];
        w_sel_a      = req_a[posit_width*idx +: posit_width];
        w_sel_b      = req_b[posit_width*idx +: posit_width];
      end
    end
  end

  assign w_handshake = (r_state == S_IDLE) && !reset && w_gnt_found;
  // Only a fresh rising edge completes an op; a done level left high from
  // the previous op is ignored.
  assign w_done_rise = unit_done & ~r_done_q;
  assign w_cnt_next  = r_cnt + 1'b1;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (w_handshake)         req_ready[w_gnt_idx] = 1'b1;
    if (r_state == S_RESP)   rsp_valid[r_grant]   = 1'b1;
  end

  assign unit_start  = (r_state == S_ISSUE);
  assign unit_opcode = r_opcode;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_cnt         <= '0;
      r_done_q      <= 1'b0;
      r_opcode      <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_done_q <= unit_done;
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_opcode <= w_sel_opcode;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_grant  <= w_gnt_idx;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (w_done_rise) begin
            r_rsp_result  <= unit_result;
            r_rsp_zero    <= unit_zero;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end else if (w_cnt_next == CNT_LAST) begin
            r_rsp_result  <= NAR;
            r_rsp_zero    <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_rr_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_op_arbiter.sv
// Testbench for posit_op_arbiter (NUM_REQ=2, posit_width=8, TIMEOUT=64).
// A stand-in arithmetic unit answers start pulses after a chosen latency;
// in manual mode the test drives unit_done/zero/result itself.

module tb_posit_op_arbiter;

  localparam int PW = 8;
  localparam int NR = 2;
  localparam int TO = 64;
  localparam int EW = 2 + 8 + 1 + 1 + 16;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [2*NR-1:0]  req_opcode;
  logic [PW*NR-1:0] req_a;
  logic [PW*NR-1:0] req_b;
  logic [NR-1:0]    rsp_valid;
  logic [PW-1:0]    rsp_result;
  logic             rsp_zero;
  logic             rsp_timeout;
  logic             unit_start;
  logic [1:0]       unit_opcode;
  logic [PW-1:0]    unit_a;
  logic [PW-1:0]    unit_b;
  logic             unit_done;
  logic             unit_zero;
  logic [PW-1:0]    unit_result;
  logic             busy;
  logic [1:0]       dbg_state;

  posit_op_arbiter #(.posit_width(PW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_timeout(rsp_timeout),
    .unit_start(unit_start), .unit_opcode(unit_opcode), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_zero(unit_zero), .unit_result(unit_result),
    .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_issued = 0;
  int n_rsp    = 0;
  int m_ptr    = 0;

  // scoreboard entry: {rsp_valid, result, zero, timeout, latency (FFFF = any)}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Stand-in unit arithmetic; 0x40 is 1.0 for multiply.
  function automatic logic [7:0] unit_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return (a == 8'h40) ? b : (b == 8'h40) ? a : p[7:0];
      default: return (a == 8'h00) ? 8'h00 : (a ^ b);
    endcase
  endfunction

  function automatic int rr_pick(input logic [1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (ptr + k) % NR;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // stand-in unit: mode 0 answers automatically after um_lat cycles, mode 1 is manual
  int          um_mode = 0;
  int          um_lat  = 1;
  int          um_cnt  = 0;
  logic [7:0]  um_res;
  always @(negedge clk) begin
    if (um_mode == 0) begin
      if (unit_done) unit_done = 1'b0;
      if (um_cnt > 0) begin
        um_cnt--;
        if (um_cnt == 0) begin
          unit_done   = 1'b1;
          unit_result = um_res;
          unit_zero   = (um_res == 8'h00);
        end
      end
      if (unit_start) begin
        um_res = unit_fn(unit_opcode, unit_a, unit_b);
        um_cnt = um_lat;
      end
    end
  end

  // response monitor
  int            cyc = 0;
  int            start_cyc = 0;
  logic [17:0]   op_snap;
  logic          ops_moved = 1'b0;
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    cyc++;
    if (unit_start) begin
      start_cyc = cyc;
      op_snap   = {unit_opcode, unit_a, unit_b};
      ops_moved = 1'b0;
    end else if (busy && ({unit_opcode, unit_a, unit_b} !== op_snap)) begin
      ops_moved = 1'b1;
    end
    if (rsp_valid !== 2'b00) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid",   32'(rsp_valid),   32'(mon_e[27:26]));
        check("rsp_result",  32'(rsp_result),  32'(mon_e[25:18]));
        check("rsp_zero",    32'(rsp_zero),    32'(mon_e[17]));
        check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e[16]));
        if (mon_e[15:0] != 16'hFFFF) check("rsp_latency", 32'(cyc - start_cyc), 32'(mon_e[15:0]));
        check("ops_stable", 32'(ops_moved), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] v, input logic [3:0] ops, input logic [15:0] as,
                       input logic [15:0] bs, input logic [1:0] e_oh, input logic [7:0] e_res,
                       input logic e_zero, input logic e_to, input logic [15:0] e_lat, input bit keep);
    int g;
    g = e_oh[1] ? 1 : 0;
    @(negedge clk);
    req_valid  = v;
    req_opcode = ops;
    req_a      = as;
    req_b      = bs;
    #1;
    check("req_ready", 32'(req_ready), 32'(e_oh));
    exp_q.push_back({e_oh, e_res, e_zero, e_to, e_lat});
    n_issued++;
    @(negedge clk);
    check("unit_start",  32'(unit_start), 32'd1);
    check("unit_opcode", 32'(unit_opcode), 32'(ops[2*g +: 2]));
    check("unit_a",      32'(unit_a), 32'(as[8*g +: 8]));
    check("unit_b",      32'(unit_b), 32'(bs[8*g +: 8]));
    if (!keep) req_valid = 2'b00;
    m_ptr = (g + 1) % NR;
  endtask

  task automatic issue_model(input logic [1:0] v, input logic [3:0] ops, input logic [15:0] as,
                             input logic [15:0] bs, input int lat, input bit keep);
    int         g;
    logic [1:0] oh;
    logic [7:0] r;
    g     = rr_pick(v, m_ptr);
    oh    = '0;
    oh[g] = 1'b1;
    r     = unit_fn(ops[2*g +: 2], as[8*g +: 8], bs[8*g +: 8]);
    um_lat = lat;
    issue(v, ops, as, bs, oh, r, (r == 8'h00), 1'b0, 16'(lat + 1), keep);
  endtask

  task automatic wait_rsp(input int bound, input string nm);
    for (int i = 0; i < bound && n_rsp < n_issued; i++) begin
      @(negedge clk);
      #1;
    end
    check(nm, 32'(n_rsp), 32'(n_issued));
    if (n_rsp != n_issued) begin
      exp_q.delete();
      n_issued = n_rsp;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, "_rsp_result"},  32'(rsp_result),  32'd0);
    check({tag, "_rsp_zero"},    32'(rsp_zero),    32'd0);
    check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    check({tag, "_unit_start"},  32'(unit_start),  32'd0);
    check({tag, "_unit_opcode"}, 32'(unit_opcode), 32'd0);
    check({tag, "_unit_a"},      32'(unit_a),      32'd0);
    check({tag, "_unit_b"},      32'(unit_b),      32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_state"},       32'(dbg_state),   32'd0);
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  ops;
    logic [15:0] as;
    logic [15:0] bs;
    int          lat;
    logic [1:0]  e_oh;
    logic [7:0]  e_res;
    logic        e_zero;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n_before;
    tbl[0] = '{2'b01, 4'b0010, 16'h0040, 16'h0040, 3, 2'b01, 8'h40, 1'b0};
    tbl[1] = '{2'b11, 4'b0100, 16'h5012, 16'h0834, 1, 2'b10, 8'h48, 1'b0};
    tbl[2] = '{2'b11, 4'b0100, 16'h5012, 16'h0834, 2, 2'b01, 8'h46, 1'b0};
    tbl[3] = '{2'b01, 4'b0001, 16'h0010, 16'h0010, 4, 2'b01, 8'h00, 1'b1};
    tbl[4] = '{2'b10, 4'b1100, 16'h0000, 16'h4000, 5, 2'b10, 8'h00, 1'b1};
    tbl[5] = '{2'b10, 4'b1000, 16'h0300, 16'h0500, 2, 2'b10, 8'h0F, 1'b0};
    tbl[6] = '{2'b11, 4'b0010, 16'h0140, 16'h017F, 1, 2'b01, 8'h7F, 1'b0};
    tbl[7] = '{2'b11, 4'b1100, 16'hA5FF, 16'h5A02, 3, 2'b10, 8'hFF, 1'b0};

    req_valid   = 2'b11;
    req_opcode  = '0;
    req_a       = '0;
    req_b       = '0;
    unit_done   = 1'b0;
    unit_zero   = 1'b0;
    unit_result = '0;

    // reset state, with requests pending to show ready stays low
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    req_valid = 2'b00;
    reset     = 1'b0;
    m_ptr     = 0;

    // table: single ops and round-robin choice between two requesters
    um_mode = 0;
    for (int i = 0; i < 8; i++) begin
      um_lat = tbl[i].lat;
      issue(tbl[i].v, tbl[i].ops, tbl[i].as, tbl[i].bs, tbl[i].e_oh, tbl[i].e_res,
            tbl[i].e_zero, 1'b0, 16'(tbl[i].lat + 1), 1'b0);
      wait_rsp(20, "tbl_rsp");
    end

    // contention: both requesters held valid across four grants
    for (int k = 0; k < 4; k++) begin
      issue_model(2'b11, 4'b0100, 16'h8021, 16'h0111, 2, (k < 3));
      wait_rsp(20, "cont_rsp");
    end

    // timeout: unit never answers
    um_mode   = 1;
    unit_done = 1'b0;
    issue(2'b01, 4'b0011, 16'h0011, 16'h0022, 2'b01, 8'h80, 1'b0, 1'b1, 16'(TO), 1'b0);
    wait_rsp(TO + 10, "to_rsp");
    @(negedge clk);
    #1;
    check("to_busy_after",   32'(busy),        32'd0);
    check("to_rsp_dropped",  32'(rsp_valid),   32'd0);
    check("to_result_held",  32'(rsp_result),  32'h80);
    check("to_flag_held",    32'(rsp_timeout), 32'd1);
    um_mode = 0;
    issue_model(2'b11, 4'b1001, 16'h3344, 16'h1122, 2, 1'b0);
    wait_rsp(20, "to_next_rsp");

    // stale done: level held from the previous op must not complete the next
    um_mode = 1;
    issue(2'b01, 4'b0000, 16'h000A, 16'h000B, 2'b01, 8'h33, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    @(negedge clk);
    unit_result = 8'h33;
    unit_zero   = 1'b0;
    unit_done   = 1'b1;
    wait_rsp(10, "stale_first_rsp");
    issue(2'b10, 4'b0100, 16'h0C00, 16'h0D00, 2'b10, 8'h55, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    n_before = n_rsp;
    repeat (6) @(negedge clk);
    #1;
    check("stale_no_rsp", 32'(n_rsp), 32'(n_before));
    check("stale_busy",   32'(busy),  32'd1);
    unit_done = 1'b0;
    @(negedge clk);
    unit_done   = 1'b1;
    unit_result = 8'h55;
    wait_rsp(10, "stale_second_rsp");
    unit_done = 1'b0;

    // divide of zero with a long unit latency and changing request inputs
    issue(2'b10, 4'b1100, 16'h0000, 16'h4000, 2'b10, 8'h00, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    req_a      = 16'hFFFF;
    req_b      = 16'hFFFF;
    req_opcode = 4'hF;
    repeat (5) @(negedge clk);
    unit_result = 8'h00;
    unit_zero   = 1'b1;
    unit_done   = 1'b1;
    @(negedge clk);
    unit_done = 1'b0;
    unit_zero = 1'b0;
    wait_rsp(10, "div_rsp");

    // reset in WAIT: move the pointer to 1 first, then abandon an op
    um_mode = 0;
    um_lat  = 2;
    issue(2'b01, 4'b0000, 16'h0005, 16'h0006, 2'b01, 8'h0B, 1'b0, 1'b0, 16'd3, 1'b0);
    wait_rsp(20, "prerst_rsp");
    um_mode = 1;
    issue(2'b10, 4'b0100, 16'h4400, 16'h1100, 2'b10, 8'h33, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
    reset     = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    n_issued  = n_rsp;
    m_ptr     = 0;
    n_before  = n_rsp;
    @(negedge clk);
    unit_result = 8'h77;
    unit_done   = 1'b1;
    @(negedge clk);
    unit_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_rsp", 32'(n_rsp), 32'(n_before));
    check("midrst_idle",   32'(busy),  32'd0);
    um_mode = 0;
    um_lat  = 2;
    issue(2'b11, 4'b0100, 16'h0907, 16'h0203, 2'b01, 8'h0A, 1'b0, 1'b0, 16'd3, 1'b0);
    wait_rsp(20, "postrst_rsp");

    // randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  v;
      logic [3:0]  ops;
      logic [15:0] as;
      logic [15:0] bs;
      v   = 2'($urandom_range(1, 3));
      ops = 4'($urandom);
      as  = 16'($urandom);
      bs  = 16'($urandom);
      issue_model(v, ops, as, bs, $urandom_range(1, 6), 1'b0);
      wait_rsp(20, "rand_rsp");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
